// File: rtl/can_crc_seq.sv
// can_crc_seq -- bit-serial CAN 2.0 CRC-15 sequencer.
//
// Takes destuffed frame bits (one i_bit_valid strobe per bit, starting at SOF),
// runs the CRC-15 LFSR over SOF..end of data, and decodes IDE/RTR/DLC on the fly
// to find where the protected field ends. In the CRC field it either presents
// the CRC bits MSB-first (TX) or collects the received CRC and compares (RX).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_sof           SOF strobe, coincident with the SOF bit's i_bit_valid
//   i_bit_valid     one-cycle strobe per destuffed bit
//   i_bit           destuffed bit value
//   i_tx_mode       1 = emit CRC, 0 = check received CRC (latched at SOF)
//   i_abort         synchronous abort, wins over any simultaneous strobe
//   o_busy          frame in progress
//   o_crc_phase     high while in the CRC field
//   o_tx_crc_bit    CRC bit for the current CRC-field position
//   o_crc           computed CRC, frozen on entry to the CRC field
//   o_dlc           captured DLC (raw value)
//   o_done          one-cycle pulse after the 15th CRC bit
//   o_crc_err       RX CRC mismatch, valid with o_done, held until next SOF
module can_crc_seq #(
   parameter logic [14:0] CRC_POLY = 15'h4599,
   parameter logic [14:0] CRC_INIT = 15'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_sof,
   input  logic        i_bit_valid,
   input  logic        i_bit,
   input  logic        i_tx_mode,
   input  logic        i_abort,
   output logic        o_busy,
   output logic        o_crc_phase,
   output logic        o_tx_crc_bit,
   output logic [14:0] o_crc,
   output logic [3:0]  o_dlc,
   output logic        o_done,
   output logic        o_crc_err
);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CRC, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [14:0] lfsr_q, lfsr_d;
   logic [6:0]  cnt_q, cnt_d;     // HDR: index of the incoming bit (SOF = 0); DATA/CRC: bits seen
   logic        tx_q, tx_d;
   logic        ide_q, ide_d;
   logic        rtr_q, rtr_d;
   logic [3:0]  dlc_q, dlc_d;
   logic [6:0]  dlen_q, dlen_d;   // data-field length in bits, 8..64
   logic [14:0] crc_q, crc_d;
   logic [14:0] rx_q, rx_d;
   logic        err_q, err_d;

   logic [14:0] lfsr_step, sof_step, rx_shift;
   logic [3:0]  dlc_new;
   logic [6:0]  data_bits;
   logic        hdr_last, in_dlc;

   assign lfsr_step = {lfsr_q[13:0], 1'b0}   ^ ((i_bit ^ lfsr_q[14])   ? CRC_POLY : 15'h0000);
   assign sof_step  = {CRC_INIT[13:0], 1'b0} ^ ((i_bit ^ CRC_INIT[14]) ? CRC_POLY : 15'h0000);
   assign rx_shift  = {rx_q[13:0], i_bit};

   // DLC arrives MSB first; on the last header bit the final nibble is not yet in dlc_q.
   assign dlc_new   = {dlc_q[2:0], i_bit};
   assign data_bits = rtr_q ? 7'd0 : (dlc_new[3] ? 7'd64 : {1'b0, dlc_new[2:0], 3'b000});
   assign hdr_last  = ide_q ? (cnt_q == 7'd38) : (cnt_q == 7'd18);
   assign in_dlc    = ide_q ? (cnt_q >= 7'd35 && cnt_q <= 7'd38)
                            : (cnt_q >= 7'd15 && cnt_q <= 7'd18);

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      ide_d   = ide_q;
      rtr_d   = rtr_q;
      dlc_d   = dlc_q;
      dlen_d  = dlen_q;
      crc_d   = crc_q;
      rx_d    = rx_q;
      err_d   = err_q;
      if (i_abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else if (i_sof && i_bit_valid) begin
         // SOF restarts from any state; the SOF bit itself is bit 0 of the CRC sequence.
         state_d = S_HDR;
         lfsr_d  = sof_step;
         cnt_d   = 7'd1;
         tx_d    = i_tx_mode;
         ide_d   = 1'b0;
         rtr_d   = 1'b0;
         dlc_d   = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            S_HDR: if (i_bit_valid) begin
               lfsr_d = lfsr_step;
               cnt_d  = cnt_q + 7'd1;
               if (cnt_q == 7'd12) rtr_d = i_bit;           // standard RTR (or SRR, overwritten later)
               if (cnt_q == 7'd13) ide_d = i_bit;
               if (ide_q && cnt_q == 7'd32) rtr_d = i_bit;  // extended RTR
               if (in_dlc) dlc_d = dlc_new;
               if (hdr_last) begin
                  cnt_d = '0;
                  if (data_bits == 7'd0) begin
                     state_d = S_CRC;
                     crc_d   = lfsr_step;
                  end else begin
                     state_d = S_DATA;
                     dlen_d  = data_bits;
                  end
               end
            end
            S_DATA: if (i_bit_valid) begin
               lfsr_d = lfsr_step;
               cnt_d  = cnt_q + 7'd1;
               if (cnt_q == dlen_q - 7'd1) begin
                  state_d = S_CRC;
                  crc_d   = lfsr_step;
                  cnt_d   = '0;
               end
            end
            S_CRC: if (i_bit_valid) begin
               rx_d  = rx_shift;
               cnt_d = cnt_q + 7'd1;
               if (cnt_q == 7'd14) begin
                  state_d = S_DONE;
                  err_d   = !tx_q && (rx_shift != crc_q);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         lfsr_q  <= CRC_INIT;
         cnt_q   <= '0;
         tx_q    <= 1'b0;
         ide_q   <= 1'b0;
         rtr_q   <= 1'b0;
         dlc_q   <= '0;
         dlen_q  <= '0;
         crc_q   <= '0;
         rx_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         ide_q   <= ide_d;
         rtr_q   <= rtr_d;
         dlc_q   <= dlc_d;
         dlen_q  <= dlen_d;
         crc_q   <= crc_d;
         rx_q    <= rx_d;
         err_q   <= err_d;
      end
   end

   assign o_busy       = (state_q != S_IDLE);
   assign o_crc_phase  = (state_q == S_CRC);
   // cnt_q stays in 0..14 while in the CRC field.
   assign o_tx_crc_bit = (state_q == S_CRC) ? crc_q[4'd14 - cnt_q[3:0]] : 1'b0;
   assign o_crc        = crc_q;
   assign o_dlc        = dlc_q;
   assign o_done       = (state_q == S_DONE);
   assign o_crc_err    = err_q;

endmodule
